// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the RV32M multiply/divide sequencer
package muldiv_pkg;
  typedef enum logic [2:0] {
    F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU, F3_DIV, F3_DIVU, F3_REM, F3_REMU
  } funct3_e;
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;
  // most-negative dividend; the top XLEN bits are taken by the user
  localparam logic [63:0] OVF_DIVIDEND_MAX = 64'h8000_0000_0000_0000;
endpackage

// File: rtl/muldiv_decode.sv
// muldiv_decode: maps funct3 to operation class and operand signedness
module muldiv_decode
  import muldiv_pkg::*;
(
  input  logic [2:0] i_funct3,
  output logic       o_is_div,
  output logic       o_is_rem,
  output logic       o_a_signed,
  output logic       o_b_signed,
  output logic       o_want_high
);
  funct3_e w_f;
  assign w_f         = funct3_e'(i_funct3);
  assign o_is_div    = i_funct3[2];
  assign o_is_rem    = i_funct3[2] & i_funct3[1];
  assign o_a_signed  = w_f inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
  assign o_b_signed  = w_f inside {F3_MULH, F3_DIV, F3_REM};
  assign o_want_high = !i_funct3[2] && w_f != F3_MUL;
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle RV32M multiply/divide sequencer with start/done handshake
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] OVF = OVF_DIVIDEND_MAX[63 -: XLEN];
  state_e            r_state;
  logic [CW-1:0]     r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_mb, r_res, r_result;
  logic              r_is_div, r_is_rem, r_high, r_a_neg, r_b_neg, r_busy, r_done;
  logic              w_is_div, w_is_rem, w_a_signed, w_b_signed, w_high;
  logic              w_a_neg, w_b_neg, w_dz, w_ovf, w_last;
  logic [XLEN-1:0]   w_mag_a, w_mag_b, w_q, w_r, w_fix_res;
  logic [XLEN:0]     w_sum, w_trial;
  logic [2*XLEN-1:0] w_prod, w_fix;
  muldiv_decode u_decode (
    .i_funct3   (funct3),
    .o_is_div   (w_is_div),
    .o_is_rem   (w_is_rem),
    .o_a_signed (w_a_signed),
    .o_b_signed (w_b_signed),
    .o_want_high(w_high)
  );
  assign w_a_neg = w_a_signed & op_a[XLEN-1];
  assign w_b_neg = w_b_signed & op_b[XLEN-1];
  assign w_mag_a = w_a_neg ? -op_a : op_a;
  assign w_mag_b = w_b_neg ? -op_b : op_b;
  assign w_dz    = w_is_div && op_b == '0;
  assign w_ovf   = w_is_div && w_b_signed && op_a == OVF && op_b == '1;
  assign w_last  = r_cnt == CW'(XLEN - 1);
  // shift-add: low half of r_acc holds the shrinking multiplier
  assign w_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mb} : '0);
  // restoring divide: r_acc = {remainder, dividend/quotient}
  assign w_trial = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_mb};
  assign w_prod  = {{XLEN{1'b0}}, w_mag_a} * {{XLEN{1'b0}}, w_mag_b};
  assign w_fix   = (r_a_neg ^ r_b_neg) ? -r_acc : r_acc;
  assign w_q     = (r_a_neg ^ r_b_neg) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_r     = r_a_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
  assign w_fix_res = r_is_div ? (r_is_rem ? w_r : w_q)
                              : (r_high ? w_fix[2*XLEN-1:XLEN] : w_fix[XLEN-1:0]);
  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mb     <= '0;
      r_res    <= '0;
      r_result <= '0;
      r_is_div <= 1'b0;
      r_is_rem <= 1'b0;
      r_high   <= 1'b0;
      r_a_neg  <= 1'b0;
      r_b_neg  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_busy <= !flush && r_state inside {S_MUL, S_DIV, S_FIX};
      r_done <= !flush && r_state == S_DONE;
      if (!flush && r_state == S_DONE) r_result <= r_res;
      if (flush) r_state <= S_IDLE;
      else case (r_state)
        S_IDLE: if (start) begin
          r_is_div <= w_is_div;
          r_is_rem <= w_is_rem;
          r_high   <= w_high;
          r_a_neg  <= w_a_neg;
          r_b_neg  <= w_b_neg;
          r_mb     <= w_mag_b;
          r_cnt    <= '0;
          r_acc    <= (w_is_div || !FAST_MUL) ? {{XLEN{1'b0}}, w_mag_a} : w_prod;
          r_res    <= w_dz ? (w_is_rem ? op_a : '1) : (w_is_rem ? '0 : op_a);
          r_state  <= (w_dz || w_ovf) ? S_DONE : w_is_div ? S_DIV : FAST_MUL ? S_FIX : S_MUL;
        end
        S_MUL: begin
          r_acc   <= {w_sum, r_acc[XLEN-1:1]};
          r_cnt   <= r_cnt + 1'b1;
          r_state <= w_last ? S_FIX : S_MUL;
        end
        S_DIV: begin
          r_acc   <= w_trial[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                   : {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
          r_cnt   <= r_cnt + 1'b1;
          r_state <= w_last ? S_FIX : S_DIV;
        end
        S_FIX: begin
          r_res   <= w_fix_res;
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle RV32M multiply/divide sequencer for the EX stage. It decodes `funct3` for the eight M-extension operations and runs them to completion:
- iterative shift-add multiply, or single-pass multiply when `FAST_MUL=1`;
- restoring division;
- one-cycle early-out for divide-by-zero and signed overflow.

It sits beside the main ALU, is selected when the ALU-control decode flags an M-type R-instruction, and holds the pipeline via a start/done handshake.

## Interface
- `XLEN`, 32: operand and result width; power of two, at least 8.
- `FAST_MUL`, 0: 0 selects the iterative multiplier (XLEN cycles); 1 selects the single-pass `*` multiplier.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: M-op request; sampled only in IDLE.
- `funct3` input 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a` input XLEN: rs1 value.
- `op_b` input XLEN: rs2 value.
- `flush` input 1: synchronous abort; has priority over `start`.
- `busy` output 1: registered; high in MUL, DIV and FIX.
- `done` output 1: registered; one-cycle pulse while in DONE.
- `result` output XLEN: registered; valid while `done` is high, held until the next completion.

## Operation
- **States:** IDLE, MUL, DIV, FIX, DONE. A counter of width $clog2(XLEN)+1 tracks iterations.
- **Accept:** an edge with state IDLE, `start=1` and `flush=0` latches `funct3`, the operands, the operand signs and the operand magnitudes.
  - Signed sources: MULH takes both signed; MULHSU takes `op_a` signed only; DIV and REM take both signed.
  - MUL uses magnitudes as unsigned (lower bits are identical).
- **Transitions out of IDLE on accept:**
  - divide with `op_b==0` → DONE; quotient = all ones, remainder = `op_a`;
  - DIV/REM with `op_a==1<<(XLEN-1)` and `op_b=='1` → DONE; quotient = `op_a`, remainder = 0;
  - any other divide → DIV;
  - multiply with `FAST_MUL=0` → MUL;
  - multiply with `FAST_MUL=1` → FIX, with the 2·XLEN product computed in that cycle.
- **MUL:** one shift-add step per cycle on a 2·XLEN accumulator. After XLEN steps → FIX.
- **DIV:** one restoring step per cycle; quotient and remainder are held in a 2·XLEN shift register. After XLEN steps → FIX.
- **FIX sign correction:**
  - product is negated if its sign is set;
  - quotient is negated if the operand signs differ (signed ops only);
  - remainder takes the sign of `op_a`.
- **FIX result select:**
  - MUL: low XLEN bits;
  - MULH, MULHSU, MULHU: high XLEN bits;
  - DIV, DIVU: quotient;
  - REM, REMU: remainder.
- FIX then goes to DONE.
- **DONE:** `done=1`, `result` is valid. Always goes to IDLE next; `start` is ignored in this cycle.
- **Start during operation:** `start` in any state other than IDLE has no effect.
- **Flush:** in any state, the next state is IDLE. `done` does not pulse, `result` keeps its old value, and the partial result is discarded.
- **Pipeline contract:** EX stalls while `start && !done`. The requester drops or changes `start` on the edge after `done`.

## Timing
- **Reset:** `rst_n` low forces, asynchronously, state IDLE, `busy=0`, `done=0`, `result=0`, counter 0, and clears all internal registers. Reset mid-operation aborts the operation with no `done`.
- **Latency:** with the accept edge at T, `done` is high in the cycle after edge T+n:
  - iterative MUL or DIV: n = XLEN+2 (34 for XLEN=32);
  - FAST_MUL multiply: n = 2;
  - divide-by-zero or overflow: n = 1.
- `busy` rises the cycle after accept and falls in the DONE cycle. It never rises for the early-out cases.
- **Back-to-back:** the minimum spacing between accepts is n+1 edges (DONE → IDLE → accept).
- **Flush and start on the same edge:** flush wins; no accept takes place. An accept can occur on the following edge.

## Structure
- **Package `muldiv_pkg`:**
  - funct3 enum: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU;
  - state enum: IDLE, MUL, DIV, FIX, DONE;
  - constant for the overflow dividend pattern.
- **Sub-module:** one is natural, `muldiv_decode`, a combinational block mapping `funct3` to {is_div, is_rem, a_signed, b_signed, want_high}. The datapath and FSM stay in `muldiv_seq`.

## Test plan
All with XLEN=32, FAST_MUL=0 unless stated.
- **MUL:** `op_a`=7, `op_b`=0xFFFFFFFD → `result`=0xFFFFFFEB. `done` lands exactly 34 cycles after accept; `busy` is high for 33 cycles.
- **High multiplies:**
  - MULH 0x80000000×0x80000000 → 0x40000000;
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE;
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- **Divide and remainder:**
  - DIV 0xFFFFFFF9/2 → 0xFFFFFFFD;
  - REM 0xFFFFFFF9/2 → 0xFFFFFFFF;
  - DIVU 100/7 → 14;
  - REMU 100/7 → 2.
- **Early-out (`done` the cycle after accept, `busy` never high):**
  - DIV 5/0 → 0xFFFFFFFF;
  - REMU 5/0 → 5;
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000;
  - REM of the same operands → 0.
- **Abort and ignore:**
  - `flush` 10 cycles into a DIV → `busy` low on the next cycle, no `done`, `result` unchanged; a new MUL accepted the following edge completes correctly;
  - `rst_n` pulsed mid-MUL → all outputs 0 immediately;
  - `start` toggled while busy → ignored.
- **FAST_MUL=1:** MUL 0x12345678×0x10 → 0x23456780, with `done` 2 cycles after accept; MULHU of the same operands → 0x1.
